lane_demux_framer: RTL and testbench
====================================

// Module: lane_demux_framer
// PURPOSE
//  Parametrised byte-stream demux for the PHY receive path. Gathers the serial symbol
//  stream (COM/SKP/STP/SDP/END/IDL plus data) into LANES-byte words and tracks COM
//  alignment and STP/SDP..END packet framing. It can also drop all-SKP words.
//  It sits after the byte mux/deserialiser and before the link-layer packet buffer.
// PARAMETERS
//  LANES     4  bytes per output word; byte k of a word goes to lane k, data_out[8k+7:8k]
//  SKP_DROP  1  1 = suppress words whose bytes are all SKP; 0 = forward them
// PORTS
//  clk_1m       in   1         single clock, all logic on posedge
//  reset_L      in   1         asynchronous, active-low reset
//  valid_in     in   1         data_in carries a symbol this cycle
//  data_in      in   8         received symbol
//  valid_out    out  1         one-cycle strobe: data_out/control_out/sop/eop valid
//  data_out     out  LANES*8   gathered word, lane 0 = first byte received
//  control_out  out  8         lane-0 byte if it is a control symbol, else 8'h00
//  sop          out  1         word contains STP or SDP that opens a packet
//  eop          out  1         word contains the END that closes a packet
//  in_pkt       out  1         framer is inside a packet (state PKT)
//  err_out      out  1         one-cycle pulse on any framing/alignment violation
// BEHAVIOUR
//  - Reset (async, reset_L=0): all outputs 0, state UNALIGNED, byte index idx=0, gather
//    register cleared. Reset mid-word or mid-packet discards everything; no partial word out.
//  - States: UNALIGNED, IDLE (aligned, between packets), PKT.
//  - UNALIGNED: every non-COM byte is discarded. A COM is stored at lane 0 with idx=1 -> IDLE.
//  - Gathering (IDLE/PKT): each valid byte is written to lane idx and idx increments.
//    On the LANES-th byte, idx wraps to 0. The word appears on the next clock:
//    valid_out=1 for exactly one cycle, so latency = 1 cycle after the last byte.
//  - A valid_in=0 with idx!=0 drops the partial word, sets idx=0, pulses err_out and
//    goes to UNALIGNED. A valid_in=0 with idx==0 is an idle gap with no effect.
//  - A COM received with idx!=0 drops the partial word, pulses err_out, and restarts the
//    word with that COM at lane 0 (idx=1). The state is kept.
//  - Framing is evaluated per byte, in order within the word:
//    IDLE+STP/SDP -> PKT, sop set for that word.
//    PKT+END -> IDLE, eop set for that word.
//    IDLE+END -> err_out pulse, stays IDLE.
//    PKT+STP/SDP -> err_out pulse, packet restarts (sop set).
//    PKT+IDL or PKT+COM -> err_out pulse, -> IDLE.
//    A word can carry both sop and eop (for example STP d d END).
//  - in_pkt reflects the registered state and changes in the cycle valid_out is asserted.
//  - SKP_DROP=1: a completed word whose LANES bytes are all SKP gives no valid_out, and
//    sop/eop/control_out are not updated. Mixed SKP words are forwarded unchanged.
//  - control_out decodes lane 0 to COM/SKP/STP/SDP/END/IDL; any other value gives 8'h00.
//  - data_out, control_out, sop and eop hold their last value when valid_out=0.
//    err_out is a single-cycle pulse, registered, and aligned with the cycle after the
//    offending byte. If an error coincides with a word completion, both pulses occur together.
// STRUCTURE
//  - Package phy_sym_pkg: symbol constants COM=8'hBC, SKP=8'h1C, STP=8'hFB, SDP=8'h5C,
//    END=8'hFD, IDL=8'h7C; function is_ctrl(byte); framer state enum
//    {UNALIGNED, IDLE, PKT}. Shared with the mux/deserialiser and the testbenches.
//  - One sub-module, byte_gather: idx counter and LANES*8 gather register, with
//    load/flush/restart inputs and a word_done output. The framer FSM, SKP filter and
//    output registers sit in lane_demux_framer.
// TESTING (LANES=4 unless noted)
//  1. Reset, bytes 55 55 BC BC BC BC -> the 55s are discarded; one cycle after the last BC:
//     valid_out=1, data_out=32'hBCBCBCBC, control_out=BC, err_out=0.
//  2. Aligned, FB 01 02 FD -> data_out=32'hFD0201FB, sop=1, eop=1, control_out=FB, in_pkt
//     returns to 0.
//  3. Twelve 1C bytes: with SKP_DROP=1 there is no valid_out; with SKP_DROP=0 there are
//     three words of 32'h1C1C1C1C with control_out=1C.
//  4. FB 03..0C FD (3 words) -> sop on word 1, in_pkt=1 on words 1-2, eop on word 3.
//     Then 5C 0D 0E FD gives a second sop+eop word with control_out=5C.
//  5. BC 01, then valid_in=0 -> err_out pulse, no word output, state UNALIGNED. Then
//     BC BC BC BC realigns and yields 32'hBCBCBCBC.
//  6. reset_L=0 midway through test 4 -> all outputs 0 immediately without a clock.
//     After release, data bytes are ignored until a COM arrives.

Source files
------------

// File: rtl/phy_sym_pkg.sv
// Receive-path symbol set and framer state shared by the byte mux/deserialiser,
// the lane demux/framer and their benches.
package phy_sym_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] END = 8'hFD;
  localparam logic [7:0] IDL = 8'h7C;

  typedef enum logic [1:0] {
    UNALIGNED = 2'd0,
    IDLE      = 2'd1,
    PKT       = 2'd2
  } framer_state_e;

  function automatic logic is_ctrl(input logic [7:0] sym);
    return (sym == COM) || (sym == SKP) || (sym == STP) ||
           (sym == SDP) || (sym == END) || (sym == IDL);
  endfunction

endpackage

// File: rtl/lane_demux_framer_if.sv
// Symbol-in / word-out bundle of the lane demux framer; slave is the framer side.
interface lane_demux_framer_if #(
  parameter int unsigned LANES = 4
);

  logic                 valid_in;
  logic [7:0]           data_in;
  logic                 valid_out;
  logic [LANES*8-1:0]   data_out;
  logic [7:0]           control_out;
  logic                 sop;
  logic                 eop;
  logic                 in_pkt;
  logic                 err_out;

  modport master (
    output valid_in, data_in,
    input  valid_out, data_out, control_out, sop, eop, in_pkt, err_out
  );

  modport slave (
    input  valid_in, data_in,
    output valid_out, data_out, control_out, sop, eop, in_pkt, err_out
  );

endinterface

// File: rtl/lane_demux_framer_byte_gather.sv
// Byte-to-word gather: lane index counter plus LANES*8 assembly register.
// The word output already includes the byte being written this cycle.
module byte_gather #(
  parameter  int unsigned LANES = 4,
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk_1m,
  input  logic               reset_L,
  input  logic               load,
  input  logic               flush,
  input  logic               restart,
  input  logic [7:0]         byte_in,
  output logic [IDX_W-1:0]   idx,
  output logic               word_done,
  output logic [LANES*8-1:0] word
);

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LANES*8-1:0] gather_q, gather_d;
  logic               last_lane;

  assign last_lane = (idx_q == IDX_W'(LANES - 1));

  always_comb begin
    idx_d    = idx_q;
    gather_d = gather_q;
    if (flush) begin
      idx_d    = '0;
      gather_d = '0;
    end else if (restart) begin
      gather_d      = '0;
      gather_d[7:0] = byte_in;
      idx_d         = IDX_W'(1);
    end else if (load) begin
      gather_d[8*idx_q +: 8] = byte_in;
      idx_d = last_lane ? '0 : idx_q + 1'b1;
    end
  end

  // NOTE: the gather register is only LANES bytes, so it is reset with the
  // counter; a mid-word reset must never leak stale bytes into a later word.
  always_ff @(posedge clk_1m or negedge reset_L) begin
    if (!reset_L) begin
      idx_q    <= '0;
      gather_q <= '0;
    end else begin
      idx_q    <= idx_d;
      gather_q <= gather_d;
    end
  end

  assign idx       = idx_q;
  assign word_done = load && !flush && !restart && last_lane;
  assign word      = gather_d;

endmodule

// File: rtl/lane_demux_framer.sv
// PHY receive demux: gathers symbols into LANES-byte words, tracks COM alignment
// and STP/SDP..END framing, optionally drops all-SKP words.
module lane_demux_framer
  import phy_sym_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter bit          SKP_DROP = 1'b1
) (
  input  logic                clk_1m,
  input  logic                reset_L,
  lane_demux_framer_if.slave  bus
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  framer_state_e      state_q, state_d;
  logic               sop_acc_q, sop_acc_d;
  logic               eop_acc_q, eop_acc_d;
  logic               com_run_q, com_run_d;

  logic               valid_out_q, valid_out_d;
  logic [LANES*8-1:0] data_out_q, data_out_d;
  logic [7:0]         control_out_q, control_out_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic               in_pkt_q, in_pkt_d;
  logic               err_q, err_d;

  logic               g_load, g_flush, g_restart, g_word_done;
  logic [IDX_W-1:0]   g_idx;
  logic [LANES*8-1:0] g_word;
  logic               frame_err, word_start, is_com, all_skp, emit;

  byte_gather #(.LANES(LANES)) u_gather (
    .clk_1m    (clk_1m),
    .reset_L   (reset_L),
    .load      (g_load),
    .flush     (g_flush),
    .restart   (g_restart),
    .byte_in   (bus.data_in),
    .idx       (g_idx),
    .word_done (g_word_done),
    .word      (g_word)
  );

  // NOTE: every variable of a combinational block gets a default first, so no
  // path through the if/case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    sop_acc_d  = sop_acc_q;
    eop_acc_d  = eop_acc_q;
    com_run_d  = com_run_q;
    g_load     = 1'b0;
    g_flush    = 1'b0;
    g_restart  = 1'b0;
    frame_err  = 1'b0;
    word_start = (g_idx == '0);
    is_com     = (bus.data_in == COM);

    if (bus.valid_in) begin
      if (state_q == UNALIGNED) begin
        if (is_com) begin
          g_restart = 1'b1;
          state_d   = IDLE;
          sop_acc_d = 1'b0;
          eop_acc_d = 1'b0;
          com_run_d = 1'b1;
        end
      end else begin
        sop_acc_d = word_start ? 1'b0 : sop_acc_q;
        eop_acc_d = word_start ? 1'b0 : eop_acc_q;
        // A COM run (e.g. BC BC BC BC) is a legal word; a COM after other bytes
        // means the lane boundary slipped, so the word restarts on that COM.
        if (is_com && !word_start && !com_run_q) begin
          g_restart = 1'b1;
          frame_err = 1'b1;
          sop_acc_d = 1'b0;
          eop_acc_d = 1'b0;
          com_run_d = 1'b1;
        end else begin
          g_load    = 1'b1;
          com_run_d = is_com && (word_start || com_run_q);
        end
        case (bus.data_in)
          STP, SDP: begin
            if (state_q == PKT) frame_err = 1'b1;
            state_d   = PKT;
            sop_acc_d = 1'b1;
          end
          END: begin
            if (state_q == PKT) begin
              state_d   = IDLE;
              eop_acc_d = 1'b1;
            end else begin
              frame_err = 1'b1;
            end
          end
          IDL, COM: begin
            if (state_q == PKT) begin
              frame_err = 1'b1;
              state_d   = IDLE;
            end
          end
          default: ;
        endcase
      end
    end else if (!word_start) begin
      g_flush   = 1'b1;
      frame_err = 1'b1;
      state_d   = UNALIGNED;
    end
  end

  always_comb begin
    all_skp = 1'b1;
    for (int k = 0; k < int'(LANES); k++) begin
      if (g_word[8*k +: 8] != SKP) all_skp = 1'b0;
    end
    emit = g_word_done && !(SKP_DROP && all_skp);

    valid_out_d   = emit;
    data_out_d    = emit ? g_word : data_out_q;
    control_out_d = control_out_q;
    if (emit) control_out_d = is_ctrl(g_word[7:0]) ? g_word[7:0] : 8'h00;
    sop_d         = emit ? sop_acc_d : sop_q;
    eop_d         = emit ? eop_acc_d : eop_q;
    // A dropped partial word leaves the framer unaligned, hence outside any packet.
    in_pkt_d      = emit ? (state_d == PKT) : (g_flush ? 1'b0 : in_pkt_q);
    err_d         = frame_err;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the comb blocks above use blocking on purpose.
  always_ff @(posedge clk_1m or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= UNALIGNED;
      sop_acc_q     <= 1'b0;
      eop_acc_q     <= 1'b0;
      com_run_q     <= 1'b0;
      valid_out_q   <= 1'b0;
      data_out_q    <= '0;
      control_out_q <= 8'h00;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      in_pkt_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sop_acc_q     <= sop_acc_d;
      eop_acc_q     <= eop_acc_d;
      com_run_q     <= com_run_d;
      valid_out_q   <= valid_out_d;
      data_out_q    <= data_out_d;
      control_out_q <= control_out_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      in_pkt_q      <= in_pkt_d;
      err_q         <= err_d;
    end
  end

  assign bus.valid_out   = valid_out_q;
  assign bus.data_out    = data_out_q;
  assign bus.control_out = control_out_q;
  assign bus.sop         = sop_q;
  assign bus.eop         = eop_q;
  assign bus.in_pkt      = in_pkt_q;
  assign bus.err_out     = err_q;

endmodule

// File: tb/tb_lane_demux_framer.sv
// Directed bench for lane_demux_framer (LANES=4): one SKP-dropping and one
// SKP-forwarding instance fed the same symbol stream.
module tb_lane_demux_framer;
  import phy_sym_pkg::*;

  logic clk_1m  = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk_1m = ~clk_1m;

  lane_demux_framer_if #(.LANES(4)) bus_a ();
  lane_demux_framer_if #(.LANES(4)) bus_b ();

  lane_demux_framer #(.LANES(4), .SKP_DROP(1'b1)) dut_a (
    .clk_1m (clk_1m),
    .reset_L(reset_L),
    .bus    (bus_a)
  );

  lane_demux_framer #(.LANES(4), .SKP_DROP(1'b0)) dut_b (
    .clk_1m (clk_1m),
    .reset_L(reset_L),
    .bus    (bus_b)
  );

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        exp_vo;
    logic [31:0] exp_data;
    logic [7:0]  exp_ctrl;
    logic        exp_sop;
    logic        exp_eop;
    logic        exp_in_pkt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic vo,
                     input logic [31:0] dat, input logic [7:0] c, input logic s,
                     input logic e, input logic ip, input logic er);
    vec_t r;
    r.valid = v; r.data = d; r.exp_vo = vo; r.exp_data = dat; r.exp_ctrl = c;
    r.exp_sop = s; r.exp_eop = e; r.exp_in_pkt = ip; r.exp_err = er;
    vecs.push_back(r);
  endtask

  // Byte that completes no word; only in_pkt and err_out are checked.
  task automatic add_b(input logic [7:0] d, input logic ip, input logic er);
    add(1'b1, d, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, ip, er);
  endtask

  // Byte that completes a forwarded word.
  task automatic add_w(input logic [7:0] d, input logic [31:0] dat, input logic [7:0] c,
                       input logic s, input logic e, input logic ip, input logic er);
    add(1'b1, d, 1'b1, dat, c, s, e, ip, er);
  endtask

  task automatic add_gap(input logic ip, input logic er);
    add(1'b0, 8'h00, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, ip, er);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk_1m);
    bus_a.valid_in = v;
    bus_a.data_in  = d;
    bus_b.valid_in = v;
    bus_b.data_in  = d;
    @(posedge clk_1m);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(vecs[i].valid, vecs[i].data);
      check($sformatf("v%0d valid_out", i), bus_a.valid_out, vecs[i].exp_vo);
      check($sformatf("v%0d err_out", i),   bus_a.err_out,   vecs[i].exp_err);
      check($sformatf("v%0d in_pkt", i),    bus_a.in_pkt,    vecs[i].exp_in_pkt);
      if (vecs[i].exp_vo) begin
        check($sformatf("v%0d data_out", i),    bus_a.data_out,    vecs[i].exp_data);
        check($sformatf("v%0d control_out", i), bus_a.control_out, vecs[i].exp_ctrl);
        check($sformatf("v%0d sop", i),         bus_a.sop,         vecs[i].exp_sop);
        check($sformatf("v%0d eop", i),         bus_a.eop,         vecs[i].exp_eop);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid_out"},   bus_a.valid_out,   1'b0);
    check({tag, " data_out"},    bus_a.data_out,    32'h0);
    check({tag, " control_out"}, bus_a.control_out, 8'h00);
    check({tag, " sop"},         bus_a.sop,         1'b0);
    check({tag, " eop"},         bus_a.eop,         1'b0);
    check({tag, " in_pkt"},      bus_a.in_pkt,      1'b0);
    check({tag, " err_out"},     bus_a.err_out,     1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    bus_a.valid_in = 1'b0; bus_a.data_in = 8'h00;
    bus_b.valid_in = 1'b0; bus_b.data_in = 8'h00;

    // Alignment from reset: 55s discarded, COM run forms a word.
    add_b(8'h55, 0, 0); add_b(8'h55, 0, 0);
    add_b(COM, 0, 0); add_b(COM, 0, 0); add_b(COM, 0, 0);
    add_w(COM, 32'hBCBCBCBC, COM, 0, 0, 0, 0);
    // Single-word packet carries sop and eop.
    add_b(STP, 0, 0); add_b(8'h01, 0, 0); add_b(8'h02, 0, 0);
    add_w(END, 32'hFD0201FB, STP, 1, 1, 0, 0);
    n1 = vecs.size();
    // Three-word packet, then an SDP single-word packet.
    add_b(STP, 0, 0); add_b(8'h03, 0, 0); add_b(8'h04, 0, 0);
    add_w(8'h05, 32'h050403FB, STP, 1, 0, 1, 0);
    add_b(8'h06, 1, 0); add_b(8'h07, 1, 0); add_b(8'h08, 1, 0);
    add_w(8'h09, 32'h09080706, 8'h00, 0, 0, 1, 0);
    add_b(8'h0A, 1, 0); add_b(8'h0B, 1, 0); add_b(8'h0C, 1, 0);
    add_w(END, 32'hFD0C0B0A, 8'h00, 0, 1, 0, 0);
    add_b(SDP, 0, 0); add_b(8'h0D, 0, 0); add_b(8'h0E, 0, 0);
    add_w(END, 32'hFD0E0D5C, SDP, 1, 1, 0, 0);
    // Mixed SKP word is forwarded.
    add_b(SKP, 0, 0); add_b(SKP, 0, 0); add_b(SKP, 0, 0);
    add_w(8'h01, 32'h011C1C1C, SKP, 0, 0, 0, 0);
    // END while idle: error, no eop.
    add_b(END, 0, 1); add_b(8'h00, 0, 0); add_b(8'h00, 0, 0);
    add_w(8'h00, 32'h000000FD, END, 0, 0, 0, 0);
    // Error on the completing byte: both pulses together.
    add_b(8'h11, 0, 0); add_b(8'h22, 0, 0); add_b(8'h33, 0, 0);
    add_w(END, 32'hFD332211, 8'h00, 0, 0, 0, 1);
    // IDL inside a packet ends it with an error.
    add_b(STP, 0, 0); add_b(IDL, 0, 1); add_b(8'h01, 0, 0);
    add_w(8'h02, 32'h02017CFB, STP, 1, 0, 0, 0);
    // SDP inside a packet restarts it, then END closes it.
    add_b(STP, 0, 0); add_b(8'h01, 0, 0); add_b(SDP, 0, 1);
    add_w(8'h02, 32'h025C01FB, STP, 1, 0, 1, 0);
    add_b(END, 1, 0); add_b(8'h00, 1, 0); add_b(8'h00, 1, 0);
    add_w(8'h00, 32'h000000FD, END, 0, 1, 0, 0);
    // Misplaced COM restarts the word.
    add_b(8'h01, 0, 0); add_b(8'h02, 0, 0); add_b(COM, 0, 1);
    add_b(8'h11, 0, 0); add_b(8'h22, 0, 0);
    add_w(8'h33, 32'h332211BC, COM, 0, 0, 0, 0);
    // Gap mid-word: error, unaligned, then realign on COMs.
    add_b(COM, 0, 0); add_b(8'h01, 0, 0); add_gap(0, 1);
    add_b(8'h01, 0, 0);
    add_b(COM, 0, 0); add_b(COM, 0, 0); add_b(COM, 0, 0);
    add_w(COM, 32'hBCBCBCBC, COM, 0, 0, 0, 0);
    // Gap on a word boundary has no effect.
    add_gap(0, 0);

    repeat (2) @(posedge clk_1m);
    #1;
    check_zero("reset");
    @(negedge clk_1m);
    reset_L = 1'b1;

    run_vecs(0, n1);

    // Twelve SKPs: dropped by dut_a, three words from dut_b.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, SKP);
      check($sformatf("skp%0d a valid_out", i), bus_a.valid_out, 1'b0);
      check($sformatf("skp%0d b valid_out", i), bus_b.valid_out, (i % 4) == 3);
      if ((i % 4) == 3) begin
        check($sformatf("skp%0d b data_out", i),    bus_b.data_out,    32'h1C1C1C1C);
        check($sformatf("skp%0d b control_out", i), bus_b.control_out, SKP);
      end
    end
    check("skp hold data_out",    bus_a.data_out,    32'hFD0201FB);
    check("skp hold control_out", bus_a.control_out, STP);
    check("skp hold sop",         bus_a.sop,         1'b1);
    check("skp hold eop",         bus_a.eop,         1'b1);

    run_vecs(n1, vecs.size());

    // Asynchronous reset in the middle of a packet.
    drive(1'b1, STP); drive(1'b1, 8'h03); drive(1'b1, 8'h04); drive(1'b1, 8'h05);
    check("pre-reset valid_out", bus_a.valid_out, 1'b1);
    check("pre-reset in_pkt",    bus_a.in_pkt,    1'b1);
    drive(1'b1, 8'h06); drive(1'b1, 8'h07);
    #2 reset_L = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk_1m);
    reset_L = 1'b1;
    bus_a.valid_in = 1'b0; bus_b.valid_in = 1'b0;
    foreach (vecs[i]) if (i < 6) begin
      drive(1'b1, 8'h0A + 8'(i));
      check($sformatf("post-reset byte%0d valid_out", i), bus_a.valid_out, 1'b0);
      check($sformatf("post-reset byte%0d err_out", i),   bus_a.err_out,   1'b0);
    end
    drive(1'b1, COM); drive(1'b1, 8'h11); drive(1'b1, 8'h22); drive(1'b1, 8'h33);
    check("realign valid_out", bus_a.valid_out, 1'b1);
    check("realign data_out",  bus_a.data_out,  32'h332211BC);
    check("realign in_pkt",    bus_a.in_pkt,    1'b0);
    drive(1'b0, 8'h00);
    check("strobe one cycle",  bus_a.valid_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
